// File: rtl/axi_mem_rw_bridge_if.sv
// AXI4 channel bundle between the SoC interconnect (master) and axi_mem_rw_bridge (slave).
interface axi_mem_rw_bridge_if #(
    parameter int ID_WIDTH = 4
);
    logic                aw_valid, aw_ready;
    logic [63:0]         aw_addr;
    logic [ID_WIDTH-1:0] aw_id;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;

    logic                w_valid, w_ready;
    logic [63:0]         w_data;
    logic [7:0]          w_strb;
    logic                w_last;

    logic                b_valid, b_ready;
    logic [ID_WIDTH-1:0] b_id;
    logic [1:0]          b_resp;

    logic                ar_valid, ar_ready;
    logic [63:0]         ar_addr;
    logic [ID_WIDTH-1:0] ar_id;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;

    logic                r_valid, r_ready;
    logic [63:0]         r_data;
    logic [ID_WIDTH-1:0] r_id;
    logic [1:0]          r_resp;
    logic                r_last;

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_data, r_id, r_resp, r_last,
        input  r_ready
    );

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_data, r_id, r_resp, r_last,
        output r_ready
    );
endinterface

// File: rtl/axi_mem_rw_bridge.sv
// AXI4 slave that splits INCR bursts into single 64-bit word accesses on the simulation memory helper.
// Define AXI_MEM_RANGE_CHECK_EN to turn out-of-range beats into DECERR instead of passing them through.
module axi_mem_rw_bridge #(
    parameter int          ID_WIDTH  = 4,
    parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
    parameter logic [63:0] MEM_WORDS = 64'h2000_0000
) (
    input  logic               clock,
    input  logic               reset,
    axi_mem_rw_bridge_if.slave axi,
    output logic               mem_enable,
    output logic               mem_r_enable,
    output logic [63:0]        mem_r_index,
    input  logic [63:0]        mem_r_data,
    output logic               mem_w_enable,
    output logic [63:0]        mem_w_index,
    output logic [63:0]        mem_w_data,
    output logic [63:0]        mem_w_mask
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    function automatic logic [63:0] base_index(input logic [63:0] addr);
        return (addr - MEM_BASE) >> 3;
    endfunction

    rd_state_t           rd_state, rd_next;
    logic [63:0]         rd_base, rd_idx;
    logic [7:0]          rd_len, rd_beat;
    logic [ID_WIDTH-1:0] rd_id;
    logic                rd_err, rd_oor, rd_last, rd_hit;

    wr_state_t           wr_state, wr_next;
    logic [63:0]         wr_base, wr_idx;
    logic [7:0]          wr_len, wr_beat;
    logic [ID_WIDTH-1:0] wr_id;
    logic                wr_err, wr_dec, wr_last, wr_hit;

    assign rd_idx  = rd_base + 64'(rd_beat);
    assign wr_idx  = wr_base + 64'(wr_beat);
    assign rd_last = (rd_beat == rd_len);
    assign wr_last = (wr_beat == wr_len);

`ifdef AXI_MEM_RANGE_CHECK_EN
    // Addresses below the base wrap to huge indices; the explicit flag keeps intent obvious.
    logic rd_below, wr_below;
    assign rd_hit = !rd_below && (rd_idx < MEM_WORDS);
    assign wr_hit = !wr_below && (wr_idx < MEM_WORDS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_below <= 1'b0;
            wr_below <= 1'b0;
        end else begin
            if (rd_state == RD_IDLE && axi.ar_valid) rd_below <= (axi.ar_addr < MEM_BASE);
            if (wr_state == WR_IDLE && axi.aw_valid) wr_below <= (axi.aw_addr < MEM_BASE);
        end
    end
`else
    assign rd_hit = 1'b1;
    assign wr_hit = 1'b1;
`endif

    assign mem_enable = !reset;

    // ---------------- read channel ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next      = rd_state;
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b0;
        mem_r_enable = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                axi.ar_ready = !reset;
                if (axi.ar_valid) rd_next = RD_ISSUE;
            end
            RD_ISSUE: begin
                mem_r_enable = rd_hit;
                rd_next      = RD_DATA;
            end
            RD_DATA: begin
                axi.r_valid = 1'b1;
                if (axi.r_ready) rd_next = rd_last ? RD_IDLE : RD_ISSUE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_base <= '0;
            rd_len  <= '0;
            rd_beat <= '0;
            rd_id   <= '0;
            rd_err  <= 1'b0;
            rd_oor  <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: if (axi.ar_valid) begin
                    rd_base <= base_index(axi.ar_addr);
                    rd_len  <= axi.ar_len;
                    rd_beat <= '0;
                    rd_id   <= axi.ar_id;
                    rd_err  <= (axi.ar_size != 3'd3) || (axi.ar_burst != BURST_INCR);
                end
                RD_ISSUE: rd_oor <= !rd_hit;
                RD_DATA:  if (axi.r_ready && !rd_last) rd_beat <= rd_beat + 8'd1;
                default: ;
            endcase
        end
    end

    // mem_r_data is held by the helper, so RD_DATA can stall indefinitely without re-reading.
    assign mem_r_index = rd_idx;
    assign axi.r_data  = rd_oor ? 64'd0 : mem_r_data;
    assign axi.r_id    = rd_id;
    assign axi.r_last  = (rd_state == RD_DATA) && rd_last;
    assign axi.r_resp  = rd_oor ? RESP_DECERR : (rd_err ? RESP_SLVERR : RESP_OKAY);

    // ---------------- write channel ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) wr_state <= WR_IDLE;
        else       wr_state <= wr_next;
    end

    always_comb begin
        wr_next      = wr_state;
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        axi.b_valid  = 1'b0;
        mem_w_enable = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                axi.aw_ready = !reset;
                if (axi.aw_valid) wr_next = WR_DATA;
            end
            WR_DATA: begin
                axi.w_ready  = 1'b1;
                mem_w_enable = axi.w_valid && wr_hit;
                if (axi.w_valid && wr_last) wr_next = WR_RESP;
            end
            WR_RESP: begin
                axi.b_valid = 1'b1;
                if (axi.b_ready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // The beat counter defines burst length; a misplaced w_last only flags the response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_base <= '0;
            wr_len  <= '0;
            wr_beat <= '0;
            wr_id   <= '0;
            wr_err  <= 1'b0;
            wr_dec  <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: if (axi.aw_valid) begin
                    wr_base <= base_index(axi.aw_addr);
                    wr_len  <= axi.aw_len;
                    wr_beat <= '0;
                    wr_id   <= axi.aw_id;
                    wr_err  <= (axi.aw_size != 3'd3) || (axi.aw_burst != BURST_INCR);
                    wr_dec  <= 1'b0;
                end
                WR_DATA: if (axi.w_valid) begin
                    if (axi.w_last != wr_last) wr_err <= 1'b1;
                    if (!wr_hit)               wr_dec <= 1'b1;
                    if (!wr_last)              wr_beat <= wr_beat + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_w_mask = '0;
        for (int i = 0; i < 8; i++) mem_w_mask[i*8 +: 8] = {8{axi.w_strb[i]}};
    end

    assign mem_w_index = wr_idx;
    assign mem_w_data  = axi.w_data;
    assign axi.b_id    = wr_id;
    assign axi.b_resp  = wr_dec ? RESP_DECERR : (wr_err ? RESP_SLVERR : RESP_OKAY);
endmodule
